// File: rtl/bg_sequencer.sv
// bg_sequencer
//   Scene controller for the pixel colour datapath. Detects frame boundaries
//   from vsync, keeps the animation frame counter, steps the background mode
//   through 0..NUM_MODES-1 with a fixed dwell per mode, inserts BLANK_FRAMES
//   of black between modes, rotates the solid colour every time mode 0 comes
//   back around, and honours the user hold/skip controls.
//
// Ports
//   clk              pixel clock
//   rst_n            synchronous, active-low reset
//   vsync            vertical sync (active-high, clk-synchronous)
//   hold             level: freeze mode and animation while high
//   skip             rising edge: jump straight to the blank before next mode
//   background_state mode code to the datapath (BLANK_CODE while blanking)
//   solid_color      {R,G,B} 2 bits each for the solid-colour mode
//   moving_counter   animation frame counter, wraps 1023 -> 0
//   mode_change      one-cycle pulse when a new mode becomes active
module bg_sequencer #(
  parameter int          NUM_MODES       = 12,
  parameter int          FRAMES_PER_MODE = 240,
  parameter int          BLANK_FRAMES    = 8,
  parameter logic [7:0]  BLANK_CODE      = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       hold,
  input  logic       skip,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic [9:0] moving_counter,
  output logic       mode_change
);

  // Counter widths are clamped to at least one bit so degenerate parameter
  // values (1 mode, 1 frame) still elaborate.
  localparam int DW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam int BW = (BLANK_FRAMES > 1)    ? $clog2(BLANK_FRAMES)    : 1;
  localparam int MW = (NUM_MODES > 1)       ? $clog2(NUM_MODES)       : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_MODE - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
  localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] dwell;
  logic [BW-1:0] blank_cnt;
  logic [MW-1:0] mode_idx;
  logic [MW-1:0] next_idx;
  logic          vsync_q;
  logic          skip_q;
  logic          frame_tick;
  logic          skip_edge;

  assign frame_tick = vsync & ~vsync_q;
  assign skip_edge  = skip & ~skip_q;
  assign next_idx   = (mode_idx == MODE_LAST) ? '0 : mode_idx + MW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_RUN;
      dwell            <= '0;
      blank_cnt        <= '0;
      mode_idx         <= '0;
      vsync_q          <= 1'b0;
      skip_q           <= 1'b0;
      background_state <= 8'd0;
      solid_color      <= 6'b110000;
      moving_counter   <= 10'd0;
      mode_change      <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      skip_q      <= skip;
      mode_change <= 1'b0;

      case (state)
        ST_RUN: begin
          // skip beats hold and a coincident frame tick: no increment then.
          if (skip_edge) begin
            state            <= ST_BLANK;
            dwell            <= '0;
            blank_cnt        <= '0;
            background_state <= BLANK_CODE;
          end else if (hold) begin
            state <= ST_HOLD;
          end else if (frame_tick) begin
            moving_counter <= moving_counter + 10'd1;
            if (dwell == DWELL_LAST) begin
              state            <= ST_BLANK;
              dwell            <= '0;
              blank_cnt        <= '0;
              background_state <= BLANK_CODE;
            end else begin
              dwell <= dwell + DW'(1);
            end
          end
        end

        ST_HOLD: begin
          if (skip_edge) begin
            state            <= ST_BLANK;
            dwell            <= '0;
            blank_cnt        <= '0;
            background_state <= BLANK_CODE;
          end else if (!hold) begin
            state <= ST_RUN;
          end
        end

        ST_BLANK: begin
          // hold and skip are ignored here; only frame ticks matter. A hold
          // still high on exit is picked up by RUN on the next cycle.
          if (frame_tick) begin
            if (blank_cnt == BLANK_LAST) begin
              state            <= ST_RUN;
              blank_cnt        <= '0;
              dwell            <= '0;
              mode_idx         <= next_idx;
              background_state <= 8'(next_idx);
              moving_counter   <= 10'd0;
              mode_change      <= 1'b1;
              if (next_idx == '0)
                solid_color <= {solid_color[1:0], solid_color[5:2]};
            end else begin
              blank_cnt <= blank_cnt + BW'(1);
            end
          end
        end

        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_sequencer.sv
// tb_bg_sequencer
//   Directed bench for bg_sequencer with NUM_MODES=3, FRAMES_PER_MODE=4,
//   BLANK_FRAMES=2, plus a second instance with FRAMES_PER_MODE=2000 used
//   to walk the animation counter to its 10-bit wrap.
module tb_bg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       hold;
  logic       skip;
  logic [7:0] background_state;
  logic [5:0] solid_color;
  logic [9:0] moving_counter;
  logic       mode_change;

  logic       vsync_w;
  logic       hold_w;
  logic       skip_w;
  logic [7:0] bg_w;
  logic [5:0] sc_w;
  logic [9:0] mc_w;
  logic       chg_w;

  int checks;
  int failures;

  bg_sequencer #(
    .NUM_MODES(3), .FRAMES_PER_MODE(4), .BLANK_FRAMES(2), .BLANK_CODE(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .hold(hold), .skip(skip),
    .background_state(background_state), .solid_color(solid_color),
    .moving_counter(moving_counter), .mode_change(mode_change)
  );

  bg_sequencer #(
    .NUM_MODES(3), .FRAMES_PER_MODE(2000), .BLANK_FRAMES(2), .BLANK_CODE(8'hFF)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_w), .hold(hold_w), .skip(skip_w),
    .background_state(bg_w), .solid_color(sc_w),
    .moving_counter(mc_w), .mode_change(chg_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vsync pulse, one cycle wide. Returns on the negedge after the
  // registered outputs have reacted to the resulting frame tick.
  task automatic pulse();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  task automatic pulse_wrap();
    @(negedge clk) vsync_w = 1'b1;
    @(negedge clk) vsync_w = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks += 4;
    if (background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_bg got=%h exp=00", background_state);
    end
    if (solid_color !== 6'b110000) begin
      failures++; $display("[TB] FAIL reset_sc got=%b exp=110000", solid_color);
    end
    if (moving_counter !== 10'd0) begin
      failures++; $display("[TB] FAIL reset_mc got=%0d exp=0", moving_counter);
    end
    if (mode_change !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_chg got=%b exp=0", mode_change);
    end
  endtask

  task automatic test_first_mode();
    for (int i = 1; i <= 3; i++) begin
      pulse();
      checks++;
      if (moving_counter !== 10'(i)) begin
        failures++; $display("[TB] FAIL run_mc%0d got=%0d exp=%0d", i, moving_counter, i);
      end
    end
    pulse();
    checks++;
    if (background_state !== 8'hFF) begin
      failures++; $display("[TB] FAIL enter_blank got=%h exp=ff", background_state);
    end
    pulse();
    checks++;
    if (background_state !== 8'hFF || mode_change !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_blank got=%h/%b exp=ff/0", background_state, mode_change);
    end
    pulse();
    checks += 4;
    if (background_state !== 8'd1) begin
      failures++; $display("[TB] FAIL mode1_bg got=%h exp=01", background_state);
    end
    if (moving_counter !== 10'd0) begin
      failures++; $display("[TB] FAIL mode1_mc got=%0d exp=0", moving_counter);
    end
    if (mode_change !== 1'b1) begin
      failures++; $display("[TB] FAIL mode1_chg got=%b exp=1", mode_change);
    end
    @(negedge clk);
    if (mode_change !== 1'b0) begin
      failures++; $display("[TB] FAIL mode1_chg_width got=%b exp=0", mode_change);
    end
  endtask

  task automatic test_full_cycle();
    // Each mode takes 4 run ticks plus 2 blank ticks.
    repeat (12) pulse();
    checks += 2;
    if (background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL wrap0_bg got=%h exp=00", background_state);
    end
    if (solid_color !== 6'b001100) begin
      failures++; $display("[TB] FAIL sc_rot1 got=%b exp=001100", solid_color);
    end
    repeat (18) pulse();
    checks += 2;
    if (background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL wrap0b_bg got=%h exp=00", background_state);
    end
    if (solid_color !== 6'b000011) begin
      failures++; $display("[TB] FAIL sc_rot2 got=%b exp=000011", solid_color);
    end
  endtask

  task automatic test_hold();
    pulse();
    @(negedge clk) hold = 1'b1;
    @(negedge clk);
    repeat (5) pulse();
    checks += 2;
    if (moving_counter !== 10'd1) begin
      failures++; $display("[TB] FAIL hold_mc got=%0d exp=1", moving_counter);
    end
    if (background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL hold_bg got=%h exp=00", background_state);
    end
    @(negedge clk) hold = 1'b0;
    @(negedge clk);
    pulse();
    checks++;
    if (moving_counter !== 10'd2) begin
      failures++; $display("[TB] FAIL release_mc got=%0d exp=2", moving_counter);
    end
    // dwell is 2 here: two ticks to blank, two more into mode 1.
    repeat (4) pulse();
    checks++;
    if (background_state !== 8'd1 || solid_color !== 6'b000011) begin
      failures++; $display("[TB] FAIL post_hold got=%h/%b exp=01/000011", background_state, solid_color);
    end
  endtask

  task automatic test_skip();
    pulse();
    @(negedge clk) begin vsync = 1'b1; skip = 1'b1; end
    @(negedge clk) vsync = 1'b0;
    checks += 2;
    if (background_state !== 8'hFF) begin
      failures++; $display("[TB] FAIL skip_bg got=%h exp=ff", background_state);
    end
    if (moving_counter !== 10'd1) begin
      failures++; $display("[TB] FAIL skip_mc got=%0d exp=1", moving_counter);
    end
    repeat (2) pulse();
    checks++;
    if (background_state !== 8'd2 || moving_counter !== 10'd0 || mode_change !== 1'b1) begin
      failures++; $display("[TB] FAIL skip_next got=%h/%0d/%b exp=02/0/1", background_state, moving_counter, mode_change);
    end
    pulse();
    checks++;
    if (background_state !== 8'd2 || moving_counter !== 10'd1) begin
      failures++; $display("[TB] FAIL skip_level got=%h/%0d exp=02/1", background_state, moving_counter);
    end
    @(negedge clk) skip = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_blank();
    @(negedge clk) skip = 1'b1;
    @(negedge clk) skip = 1'b0;
    pulse();
    checks++;
    if (background_state !== 8'hFF) begin
      failures++; $display("[TB] FAIL pre_rst_blank got=%h exp=ff", background_state);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    checks += 4;
    if (background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL rst_bg got=%h exp=00", background_state);
    end
    if (solid_color !== 6'b110000) begin
      failures++; $display("[TB] FAIL rst_sc got=%b exp=110000", solid_color);
    end
    if (moving_counter !== 10'd0) begin
      failures++; $display("[TB] FAIL rst_mc got=%0d exp=0", moving_counter);
    end
    if (mode_change !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_chg got=%b exp=0", mode_change);
    end
    pulse();
    checks++;
    if (moving_counter !== 10'd1 || background_state !== 8'd0) begin
      failures++; $display("[TB] FAIL rst_run got=%0d/%h exp=1/00", moving_counter, background_state);
    end
  endtask

  task automatic test_counter_wrap();
    repeat (1023) pulse_wrap();
    checks++;
    if (mc_w !== 10'd1023) begin
      failures++; $display("[TB] FAIL wrap_pre got=%0d exp=1023", mc_w);
    end
    pulse_wrap();
    checks += 2;
    if (mc_w !== 10'd0) begin
      failures++; $display("[TB] FAIL wrap_zero got=%0d exp=0", mc_w);
    end
    if (bg_w !== 8'd0) begin
      failures++; $display("[TB] FAIL wrap_bg got=%h exp=00", bg_w);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    vsync    = 1'b0;
    hold     = 1'b0;
    skip     = 1'b0;
    vsync_w  = 1'b0;
    hold_w   = 1'b0;
    skip_w   = 1'b0;
    test_reset();
    test_first_mode();
    test_full_cycle();
    test_hold();
    test_skip();
    test_reset_in_blank();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
